// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - per-FU result queues with round-robin arbitration onto the common data bus
// Optional same-cycle forwarding of results into empty queues: define CDB_ARB_BYPASS_EN.
module cdb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  // result layout: {rob_idx[5:0], pd_s[5:0], rd_s[4:0], rd_v[31:0], valid}
  input  logic [49:0] cdb_add,
  input  logic [49:0] cdb_mul,
  input  logic [49:0] cdb_div,
  output logic [49:0] cdb_out,
  output logic        full_add,
  output logic        full_mul,
  output logic        full_div,
  output logic [2:0]  overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [1:0] SRC_DIV = 2'd2;

  logic [49:0]   in_res [3];
  logic [48:0]   mem    [3][DEPTH];
  logic [AW-1:0] head   [3];
  logic [AW-1:0] tail   [3];
  logic [CW-1:0] cnt    [3];
  logic [1:0]    last_grant;

  logic [2:0]    byp;
  logic [2:0]    cand;
  logic [2:0]    enq;
  logic [2:0]    deq;
  logic [2:0]    drop;
  logic          gnt_vld;
  logic [1:0]    gnt_idx;
  logic [48:0]   gnt_data;

  assign in_res[0] = cdb_add;
  assign in_res[1] = cdb_mul;
  assign in_res[2] = cdb_div;

  // k-th source in round-robin order after base (add=0, mul=1, div=2)
  function automatic logic [1:0] rr_src(input logic [1:0] base, input int k);
    int s;
    s = (int'(base) + 1 + k) % 3;
    return 2'(s);
  endfunction

  always_comb begin
    byp = 3'b000;
`ifdef CDB_ARB_BYPASS_EN
    for (int i = 0; i < 3; i++) begin
      byp[i] = in_res[i][0] && (cnt[i] == '0) && !rst && !flush;
    end
`endif
    for (int i = 0; i < 3; i++) begin
      cand[i] = (cnt[i] != '0) || byp[i];
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 2'd0;
    for (int k = 0; k < 3; k++) begin
      if (!gnt_vld && cand[rr_src(last_grant, k)]) begin
        gnt_vld = 1'b1;
        gnt_idx = rr_src(last_grant, k);
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    if (gnt_vld) begin
      if (byp[gnt_idx]) gnt_data = in_res[gnt_idx][49:1];
      else              gnt_data = mem[gnt_idx][head[gnt_idx]];
    end
    cdb_out = gnt_vld ? {gnt_data, 1'b1} : '0;
  end

  // A full queue still accepts when its head leaves in the same cycle.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      logic won_byp;
      logic accept;
      won_byp = gnt_vld && (gnt_idx == 2'(i)) && byp[i];
      deq[i]  = gnt_vld && (gnt_idx == 2'(i)) && !byp[i];
      accept  = in_res[i][0] && !rst && !flush && !won_byp;
      enq[i]  = accept && ((cnt[i] != DEPTH_C) || deq[i]);
      drop[i] = accept && (cnt[i] == DEPTH_C) && !deq[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (enq[i]) mem[i][tail[i]] <= in_res[i][49:1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        head[i] <= '0;
        tail[i] <= '0;
        cnt[i]  <= '0;
      end
      last_grant <= SRC_DIV;
      overflow   <= 3'b000;
    end else begin
      overflow <= overflow | drop;
      if (flush) begin
        for (int i = 0; i < 3; i++) begin
          head[i] <= '0;
          tail[i] <= '0;
          cnt[i]  <= '0;
        end
        last_grant <= SRC_DIV;
      end else begin
        if (gnt_vld) last_grant <= gnt_idx;
        for (int i = 0; i < 3; i++) begin
          if (enq[i]) tail[i] <= tail[i] + 1'b1;
          if (deq[i]) head[i] <= head[i] + 1'b1;
          if (enq[i] && !deq[i])      cnt[i] <= cnt[i] + 1'b1;
          else if (deq[i] && !enq[i]) cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

  assign full_add = (cnt[0] == DEPTH_C);
  assign full_mul = (cnt[1] == DEPTH_C);
  assign full_div = (cnt[2] == DEPTH_C);

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter (default build)
module tb_cdb_arbiter;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [49:0] cdb_add;
  logic [49:0] cdb_mul;
  logic [49:0] cdb_div;
  logic [49:0] cdb_out;
  logic        full_add;
  logic        full_mul;
  logic        full_div;
  logic [2:0]  overflow;

  int checks;
  int failures;

  cdb_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .cdb_add(cdb_add), .cdb_mul(cdb_mul), .cdb_div(cdb_div),
    .cdb_out(cdb_out),
    .full_add(full_add), .full_mul(full_mul), .full_div(full_div),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [49:0] mk(input logic [5:0] rob, input logic [5:0] pd,
                                     input logic [4:0] rd, input logic [31:0] v);
    return {rob, pd, rd, v, 1'b1};
  endfunction

  // tagged result: rob = src*16 + n, rd_s = src+1
  function automatic logic [49:0] tag(input int src, input int n);
    return mk(6'(src * 16 + n), 6'(n + 1), 5'(src + 1), 32'hA500_0000 | 32'(src * 16 + n));
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    cdb_add = '0;
    cdb_mul = '0;
    cdb_div = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    clear_in();
    next();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (cdb_out !== 50'd0) begin
      failures++; $display("FAIL reset_cdb_out got=%h exp=0", cdb_out);
    end
    checks++;
    if ({full_div, full_mul, full_add} !== 3'b000) begin
      failures++; $display("FAIL reset_full got=%b exp=000", {full_div, full_mul, full_add});
    end
    checks++;
    if (overflow !== 3'b000) begin
      failures++; $display("FAIL reset_overflow got=%b exp=000", overflow);
    end
  endtask

  task automatic test_single();
    logic [49:0] r;
    r = mk(6'd5, 6'd12, 5'd3, 32'hDEADBEEF);
    do_reset();
    cdb_add = r;
    @(negedge clk);
    checks++;
    if (cdb_out !== 50'd0) begin
      failures++; $display("FAIL single_t got=%h exp=0", cdb_out);
    end
    next();
    clear_in();
    @(negedge clk);
    checks++;
    if (cdb_out !== r) begin
      failures++; $display("FAIL single_t1 got=%h exp=%h", cdb_out, r);
    end
    next();
    @(negedge clk);
    checks++;
    if (cdb_out !== 50'd0) begin
      failures++; $display("FAIL single_t2 got=%h exp=0", cdb_out);
    end
  endtask

  task automatic test_simultaneous();
    logic [49:0] exp_seq [4];
    do_reset();
    cdb_add = tag(0, 1);
    cdb_mul = tag(1, 1);
    cdb_div = tag(2, 1);
    exp_seq[0] = tag(0, 1);
    exp_seq[1] = tag(1, 1);
    exp_seq[2] = tag(2, 1);
    exp_seq[3] = '0;
    next();
    clear_in();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (cdb_out !== exp_seq[k]) begin
        failures++; $display("FAIL simul_t%0d got=%h exp=%h", k + 1, cdb_out, exp_seq[k]);
      end
      next();
    end
    checks++;
    if (overflow !== 3'b000) begin
      failures++; $display("FAIL simul_overflow got=%b exp=000", overflow);
    end
  endtask

  task automatic test_fairness();
    int exp_add;
    int mul_cycle;
    do_reset();
    exp_add = 0;
    mul_cycle = -1;
    for (int c = 0; c < 12; c++) begin
      cdb_add = (c < 6) ? tag(0, c) : '0;
      cdb_mul = (c == 0) ? tag(1, 9) : '0;
      @(negedge clk);
      if (cdb_out[0]) begin
        if (cdb_out === tag(1, 9)) begin
          mul_cycle = c;
        end else begin
          checks++;
          if (cdb_out !== tag(0, exp_add)) begin
            failures++; $display("FAIL fair_add_order got=%h exp=%h", cdb_out, tag(0, exp_add));
          end
          exp_add++;
        end
      end
      next();
    end
    clear_in();
    checks++;
    if (mul_cycle != 2) begin
      failures++; $display("FAIL fair_mul_cycle got=%0d exp=2", mul_cycle);
    end
    checks++;
    if (exp_add != 6) begin
      failures++; $display("FAIL fair_add_count got=%0d exp=6", exp_add);
    end
  endtask

  task automatic test_full_overflow();
    logic [7:0] acc [3];
    logic [7:0] seen [3];
    int last_n [3];
    int total;
    acc[0] = 8'b1011_1111;
    acc[1] = 8'b0011_1111;
    acc[2] = 8'b0101_1111;
    for (int s = 0; s < 3; s++) begin
      seen[s] = '0;
      last_n[s] = -1;
    end
    total = 0;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      if (c < 8) begin
        cdb_add = tag(0, c);
        cdb_mul = tag(1, c);
        cdb_div = tag(2, c);
      end else begin
        clear_in();
      end
      @(negedge clk);
      if (c == 5) begin
        checks++;
        if ({full_div, full_mul, full_add} !== 3'b110) begin
          failures++; $display("FAIL full_c5 got=%b exp=110", {full_div, full_mul, full_add});
        end
      end
      if (c == 6) begin
        checks++;
        if ({full_div, full_mul, full_add} !== 3'b111) begin
          failures++; $display("FAIL full_c6 got=%b exp=111", {full_div, full_mul, full_add});
        end
      end
      if (cdb_out[0]) begin
        int s;
        int n;
        s = int'(cdb_out[49:48]);
        n = int'(cdb_out[47:44]);
        total++;
        checks++;
        if (s > 2 || n > 7 || cdb_out !== tag(s, n) || !acc[s][n] || seen[s][n] || n <= last_n[s]) begin
          failures++; $display("FAIL full_result got=%h src=%0d n=%0d", cdb_out, s, n);
        end else begin
          seen[s][n] = 1'b1;
          last_n[s] = n;
        end
      end
      next();
    end
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (seen[s] !== acc[s]) begin
        failures++; $display("FAIL full_seen_src%0d got=%b exp=%b", s, seen[s], acc[s]);
      end
    end
    checks++;
    if (total != 19) begin
      failures++; $display("FAIL full_total got=%0d exp=19", total);
    end
    checks++;
    if (overflow !== 3'b111) begin
      failures++; $display("FAIL full_overflow got=%b exp=111", overflow);
    end
    checks++;
    if ({full_div, full_mul, full_add} !== 3'b000) begin
      failures++; $display("FAIL full_drained got=%b exp=000", {full_div, full_mul, full_add});
    end
  endtask

  task automatic test_reset_midstream();
    // entered with overflow=111 left over from the previous scenario
    cdb_add = tag(0, 1); cdb_mul = tag(1, 1); cdb_div = tag(2, 1);
    next();
    cdb_add = tag(0, 2); cdb_mul = tag(1, 2); cdb_div = tag(2, 2);
    next();
    rst = 1'b1;
    cdb_add = tag(0, 3); cdb_mul = tag(1, 3); cdb_div = tag(2, 3);
    next();
    rst = 1'b0;
    clear_in();
    cdb_mul = tag(1, 4);
    cdb_add = tag(0, 4);
    @(negedge clk);
    checks++;
    if (cdb_out !== 50'd0) begin
      failures++; $display("FAIL rstmid_cdb_out got=%h exp=0", cdb_out);
    end
    checks++;
    if (overflow !== 3'b000) begin
      failures++; $display("FAIL rstmid_overflow got=%b exp=000", overflow);
    end
    checks++;
    if ({full_div, full_mul, full_add} !== 3'b000) begin
      failures++; $display("FAIL rstmid_full got=%b exp=000", {full_div, full_mul, full_add});
    end
    next();
    clear_in();
    @(negedge clk);
    checks++;
    if (cdb_out !== tag(0, 4)) begin
      failures++; $display("FAIL rstmid_first got=%h exp=%h", cdb_out, tag(0, 4));
    end
    next();
    @(negedge clk);
    checks++;
    if (cdb_out !== tag(1, 4)) begin
      failures++; $display("FAIL rstmid_second got=%h exp=%h", cdb_out, tag(1, 4));
    end
    next();
    @(negedge clk);
    checks++;
    if (cdb_out !== 50'd0) begin
      failures++; $display("FAIL rstmid_idle got=%h exp=0", cdb_out);
    end
    next();
  endtask

  task automatic test_flush();
    do_reset();
    // c0..c4 leave add={a2,a3,a4}, mul={m2,m3}, last grant = mul
    for (int c = 0; c < 5; c++) begin
      cdb_add = tag(0, c);
      cdb_mul = (c != 2) ? tag(1, (c > 2) ? c - 1 : c) : '0;
      next();
    end
    flush = 1'b1;
    cdb_add = tag(0, 9);
    cdb_mul = '0;
    @(negedge clk);
    checks++;
    if (cdb_out !== tag(0, 2)) begin
      failures++; $display("FAIL flush_cycle got=%h exp=%h", cdb_out, tag(0, 2));
    end
    next();
    flush = 1'b0;
    cdb_add = tag(0, 12);
    cdb_mul = tag(1, 12);
    @(negedge clk);
    checks++;
    if (cdb_out !== 50'd0) begin
      failures++; $display("FAIL flush_after got=%h exp=0", cdb_out);
    end
    checks++;
    if ({full_div, full_mul, full_add, overflow} !== 6'd0) begin
      failures++; $display("FAIL flush_flags got=%b/%b exp=000/000", {full_div, full_mul, full_add}, overflow);
    end
    next();
    clear_in();
    @(negedge clk);
    checks++;
    if (cdb_out !== tag(0, 12)) begin
      failures++; $display("FAIL flush_new_add got=%h exp=%h", cdb_out, tag(0, 12));
    end
    next();
    @(negedge clk);
    checks++;
    if (cdb_out !== tag(1, 12)) begin
      failures++; $display("FAIL flush_new_mul got=%h exp=%h", cdb_out, tag(1, 12));
    end
    next();
    @(negedge clk);
    checks++;
    if (cdb_out !== 50'd0) begin
      failures++; $display("FAIL flush_drained got=%h exp=0", cdb_out);
    end
    next();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    flush = 1'b0;
    clear_in();
    next();
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_full_overflow();
    test_reset_midstream();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
